// File: rtl/bit_recover_dpll_pkg.sv
// Shared constants and helpers for the oversampling bit-recovery DPLL.
// Tracking-mode selectors and a width helper used by every instance.
package bit_recover_dpll_pkg;

    localparam int TRACK_HARD    = 0;
    localparam int TRACK_GRADUAL = 1;
    localparam int LOCK_W        = 8;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bit_recover_dpll_majority.sv
// Combinational N-input majority used for the per-bit sample vote.
// N is odd, so a strict "more than half" compare never ties.
module majority_vote
    import bit_recover_dpll_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] bits_i,
    output logic         maj_o
);

    localparam int CW = clog2(N + 1);

    logic [CW-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + CW'(bits_i[i]);
        end
        maj_o = (ones > CW'(N / 2));
    end

endmodule

// File: rtl/bit_recover_dpll.sv
// Oversampling bit recoverer: synchronizer, tick divider, phase-tracking
// DPLL, majority vote per bit and a clean-period lock indicator.
module bit_recover_dpll
    import bit_recover_dpll_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BPS       = 195_000,
    parameter int OSR       = 8,
    parameter int VOTE      = 3,
    parameter int TRACK     = 1,
    parameter int LOCK_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic dout,
    output logic drdy,
    output logic locked
);

    localparam int TICK_DIV = CLK_HZ / (BPS * OSR);
    localparam int W_LO     = OSR / 2 - (VOTE - 1) / 2;
    localparam int W_HI     = OSR / 2 + (VOTE - 1) / 2;
    localparam int TW       = clog2(TICK_DIV);
    localparam int PW       = clog2(OSR);

    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0]     PH_LAST   = PW'(OSR - 1);
    localparam logic [PW-1:0]     PH_LO     = PW'(W_LO);
    localparam logic [PW-1:0]     PH_HI     = PW'(W_HI);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_BITS);

    logic              s1_q, s2_q, s3_q;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              pend_q, pend_d;
    logic [PW-1:0]     ph_q, ph_d;
    logic              dout_q, dout_d;
    logic              drdy_q, drdy_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              bad_seen_q, bad_seen_d;

    logic            edge_det, tick, hit, in_win, bad, decide, maj;
    logic [PW-1:0]   ph_inc, ph_adv;
    logic [VOTE-1:0] samp_next;

    assign edge_det = s2_q ^ s3_q;
    assign tick     = en && (tcnt_q == TICK_LAST);
    assign hit      = pend_q | edge_det;
    assign in_win   = (ph_q >= PH_LO) && (ph_q <= PH_HI);
    assign bad      = tick && hit && in_win;
    assign decide   = tick && (ph_q == PH_HI);

    assign ph_inc = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
    assign ph_adv = (ph_q == PH_LAST) ? PW'(1) :
                    (ph_q == PH_LAST - PW'(1)) ? '0 : ph_q + PW'(2);

    // Only VOTE-1 earlier samples are stored; the live s2 completes the set
    // on the deciding tick so dout is registered on that same edge.
    if (VOTE > 1) begin : g_hist
        logic [VOTE-2:0] hist_q, hist_d;

        assign samp_next = {hist_q, s2_q};

        always_comb begin
            hist_d = hist_q;
            if (tick && in_win) hist_d = samp_next[VOTE-2:0];
            if (!en) hist_d = '0;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) hist_q <= '0;
            else        hist_q <= hist_d;
        end
    end else begin : g_single
        assign samp_next = s2_q;
    end

    majority_vote #(.N(VOTE)) u_vote (
        .bits_i (samp_next),
        .maj_o  (maj)
    );

    always_comb begin
        tcnt_d = tick ? '0 : tcnt_q + TW'(1);
        pend_d = tick ? 1'b0 : (pend_q | edge_det);
        ph_d   = ph_q;
        if (tick) begin
            ph_d = ph_inc;
            if (hit && (ph_q != '0) && !in_win) begin
                if (TRACK == TRACK_HARD) ph_d = PW'(1);
                else if (ph_q < PH_LO)   ph_d = ph_q;
                else                     ph_d = ph_adv;
            end
        end
        if (!en) begin
            tcnt_d = '0;
            pend_d = 1'b0;
            ph_d   = '0;
        end
    end

    always_comb begin
        dout_d     = decide ? maj : dout_q;
        drdy_d     = decide;
        lock_d     = lock_q;
        bad_seen_d = bad_seen_q;
        if (decide) begin
            bad_seen_d = 1'b0;
            if (!bad_seen_q && (lock_q < LOCK_MAX)) lock_d = lock_q + LOCK_W'(1);
        end
        // A bad edge on the deciding tick belongs to the bit just decided.
        if (bad) begin
            lock_d = '0;
            if (!decide) bad_seen_d = 1'b1;
        end
        if (!en) begin
            lock_d     = '0;
            bad_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            tcnt_q     <= '0;
            pend_q     <= 1'b0;
            ph_q       <= '0;
            dout_q     <= 1'b0;
            drdy_q     <= 1'b0;
            lock_q     <= '0;
            bad_seen_q <= 1'b0;
        end else begin
            s1_q       <= din;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            tcnt_q     <= tcnt_d;
            pend_q     <= pend_d;
            ph_q       <= ph_d;
            dout_q     <= dout_d;
            drdy_q     <= drdy_d;
            lock_q     <= lock_d;
            bad_seen_q <= bad_seen_d;
        end
    end

    assign dout   = dout_q;
    assign drdy   = drdy_q;
    assign locked = (lock_q == LOCK_MAX);

endmodule
